// File: rtl/move_controller.sv
// move_controller: sequences one 2048 move on the 3x3 board. A direction pulse
// starts the move; each of the three lines is slid and merged in its own cycle,
// then a tile is spawned if anything moved, and finally the board is tested
// for a loss. Owns the board register and a free-running LFSR for spawning.
module move_controller #(
  parameter int          CELL_W     = 3,
  parameter int          MAX_CODE   = 7,
  parameter int          SPAWN_CODE = 1,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r,
  input  logic                  l,
  input  logic                  u,
  input  logic                  d,
  input  logic                  ld,
  input  logic [9*CELL_W-1:0]   ld_grid,
  output logic [9*CELL_W-1:0]   grid,
  output logic                  lose,
  output logic                  busy
);

  localparam int                GW         = 9 * CELL_W;
  localparam logic [CELL_W-1:0] MAX_C      = CELL_W'(MAX_CODE);
  localparam logic [CELL_W-1:0] SPAWN_C    = CELL_W'(SPAWN_CODE);
  localparam logic [GW-1:0]     RESET_GRID = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LINE0, S_LINE1, S_LINE2, S_SPAWN, S_CHECK
  } state_e;

  typedef enum logic [1:0] {
    DIR_R, DIR_L, DIR_U, DIR_D
  } dir_e;

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [GW-1:0]     grid_q, grid_d;
  logic [GW-1:0]     snap_q, snap_d;
  logic              lose_q, lose_d;
  logic [7:0]        lfsr_q, lfsr_d;

  logic [CELL_W-1:0] xLine [3];
  logic [CELL_W-1:0] yLine [3];
  logic [CELL_W-1:0] cellA, cellB;
  int                lineK;
  int                spawnBase;
  int                spawnIdx;
  logic              spawnDone;
  logic              lossNow;

  // Board cell index of element j of line k, where element 0 sits on the edge
  // the tiles are moving toward.
  function automatic int cellIdx(input dir_e dir, input int k, input int j);
    case (dir)
      DIR_L:   return k * 3 + j;
      DIR_R:   return k * 3 + (2 - j);
      DIR_U:   return j * 3 + k;
      default: return (2 - j) * 3 + k;
    endcase
  endfunction

  function automatic logic [CELL_W-1:0] cellAt(input logic [GW-1:0] g, input int i);
    return g[i*CELL_W +: CELL_W];
  endfunction

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, stepping every cycle regardless of state.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // State, board, snapshot, direction, loss flag and LFSR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_R;
      grid_q  <= RESET_GRID;
      snap_q  <= RESET_GRID;
      lose_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      grid_q  <= grid_d;
      snap_q  <= snap_d;
      lose_q  <= lose_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Next-state logic: input acceptance in IDLE, one line per LINE state,
  // tile spawn when the board changed, then the loss test.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    grid_d    = grid_q;
    snap_d    = snap_q;
    lose_d    = lose_q;
    lineK     = 0;
    spawnBase = 0;
    spawnIdx  = 0;
    spawnDone = 1'b0;
    lossNow   = 1'b0;
    cellA     = '0;
    cellB     = '0;
    for (int j = 0; j < 3; j++) begin
      xLine[j] = '0;
      yLine[j] = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (ld) begin
          grid_d = ld_grid;
          lose_d = 1'b0;
        end else if (!lose_q && (r || l || u || d)) begin
          if (r)      dir_d = DIR_R;
          else if (l) dir_d = DIR_L;
          else if (u) dir_d = DIR_U;
          else        dir_d = DIR_D;
          snap_d  = grid_q;
          state_d = S_LINE0;
        end
      end

      S_LINE0, S_LINE1, S_LINE2: begin
        lineK = (state_q == S_LINE0) ? 0 : (state_q == S_LINE1) ? 1 : 2;
        for (int j = 0; j < 3; j++) begin
          xLine[j] = cellAt(grid_q, cellIdx(dir_q, lineK, j));
          yLine[j] = xLine[j];
        end
        // Two bubble passes are enough to pack three cells toward element 0
        // while keeping the order of the nonzero tiles.
        for (int p = 0; p < 2; p++) begin
          for (int j = 0; j < 2; j++) begin
            if (yLine[j] == '0) begin
              yLine[j]   = yLine[j+1];
              yLine[j+1] = '0;
            end
          end
        end
        // A single merge decision per line guarantees no tile merges twice.
        if (yLine[0] == yLine[1] && yLine[0] != '0 && yLine[0] < MAX_C) begin
          yLine[0] = yLine[0] + 1'b1;
          yLine[1] = yLine[2];
          yLine[2] = '0;
        end else if (yLine[1] == yLine[2] && yLine[1] != '0 && yLine[1] < MAX_C) begin
          yLine[1] = yLine[1] + 1'b1;
          yLine[2] = '0;
        end
        for (int j = 0; j < 3; j++) begin
          grid_d[cellIdx(dir_q, lineK, j)*CELL_W +: CELL_W] = yLine[j];
        end
        state_d = (state_q == S_LINE0) ? S_LINE1 :
                  (state_q == S_LINE1) ? S_LINE2 : S_SPAWN;
      end

      S_SPAWN: begin
        if (grid_q != snap_q) begin
          spawnBase = int'(lfsr_q[3:0]) % 9;
          for (int i = 0; i < 9; i++) begin
            spawnIdx = spawnBase + i;
            if (spawnIdx >= 9) spawnIdx = spawnIdx - 9;
            if (!spawnDone && cellAt(grid_q, spawnIdx) == '0) begin
              grid_d[spawnIdx*CELL_W +: CELL_W] = SPAWN_C;
              spawnDone = 1'b1;
            end
          end
        end
        state_d = S_CHECK;
      end

      S_CHECK: begin
        lossNow = 1'b1;
        for (int i = 0; i < 9; i++) begin
          if (cellAt(grid_q, i) == '0) lossNow = 1'b0;
        end
        for (int rr = 0; rr < 3; rr++) begin
          for (int cc = 0; cc < 2; cc++) begin
            cellA = cellAt(grid_q, rr * 3 + cc);
            cellB = cellAt(grid_q, rr * 3 + cc + 1);
            if (cellA == cellB && cellA < MAX_C) lossNow = 1'b0;
          end
        end
        for (int rr = 0; rr < 2; rr++) begin
          for (int cc = 0; cc < 3; cc++) begin
            cellA = cellAt(grid_q, rr * 3 + cc);
            cellB = cellAt(grid_q, (rr + 1) * 3 + cc);
            if (cellA == cellB && cellA < MAX_C) lossNow = 1'b0;
          end
        end
        if (lossNow) lose_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign grid = grid_q;
  assign lose = lose_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller: directed moves on hand-built boards. Each move pushes its
// expected final board and loss flag into a scoreboard; a monitor pops and
// compares whenever busy falls at the end of a move.
module tb_move_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r = 1'b0, l = 1'b0, u = 1'b0, d = 1'b0;
  logic        ld = 1'b0;
  logic [26:0] ld_grid = '0;
  logic [26:0] grid;
  logic        lose;
  logic        busy;

  typedef struct {
    logic [26:0] gridExp;
    logic        loseExp;
    string       name;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tbLfsr;
  logic        busyPrev = 1'b0;
  int          busyCnt = 0;

  move_controller dut (
    .clk     (clk),
    .rst     (rst),
    .r       (r),
    .l       (l),
    .u       (u),
    .d       (d),
    .ld      (ld),
    .ld_grid (ld_grid),
    .grid    (grid),
    .lose    (lose),
    .busy    (busy)
  );

  // 10 ns update clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] stepLfsr(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR so spawn positions can be predicted at stimulus time.
  always @(posedge clk or posedge rst) begin
    if (rst) tbLfsr <= 8'hA5;
    else     tbLfsr <= stepLfsr(tbLfsr);
  end

  function automatic logic [26:0] mk(input int c0, input int c1, input int c2,
                                     input int c3, input int c4, input int c5,
                                     input int c6, input int c7, input int c8);
    logic [26:0] g;
    g = '0;
    g[2:0]   = 3'(c0);
    g[5:3]   = 3'(c1);
    g[8:6]   = 3'(c2);
    g[11:9]  = 3'(c3);
    g[14:12] = 3'(c4);
    g[17:15] = 3'(c5);
    g[20:18] = 3'(c6);
    g[23:21] = 3'(c7);
    g[26:24] = 3'(c8);
    return g;
  endfunction

  function automatic logic [26:0] spawnTile(input logic [26:0] g, input logic [7:0] lv);
    logic [26:0] res;
    int          s;
    int          idx;
    logic        done;
    res  = g;
    done = 1'b0;
    s    = int'(lv[3:0]) % 9;
    for (int i = 0; i < 9; i++) begin
      idx = (s + i) % 9;
      if (!done && g[idx*3 +: 3] == 3'd0) begin
        res[idx*3 +: 3] = 3'd1;
        done = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one direction pulse for a single cycle and queues the expected
  // outcome. Called at a falling edge; returns one falling edge later.
  task automatic applyStimulus(input logic pr, input logic pl, input logic pu,
                               input logic pd, input logic [26:0] pre,
                               input logic [26:0] post, input logic loseExp,
                               input string name);
    logic [7:0] lv;
    exp_t       e;
    r = pr; l = pl; u = pu; d = pd;
    lv = tbLfsr;
    repeat (4) lv = stepLfsr(lv);
    e.gridExp = (post != pre) ? spawnTile(post, lv) : post;
    e.loseExp = loseExp;
    e.name    = name;
    sbQ.push_back(e);
    @(negedge clk);
    r = 1'b0; l = 1'b0; u = 1'b0; d = 1'b0;
  endtask

  task automatic loadGrid(input logic [26:0] g, input string name);
    ld = 1'b1;
    ld_grid = g;
    @(negedge clk);
    ld = 1'b0;
    checkOutput({name, " grid"}, 32'(grid), 32'(g));
    checkOutput({name, " lose"}, 32'(lose), 32'd0);
  endtask

  task automatic waitIdle(input string name);
    int cyc;
    cyc = 0;
    while ((sbQ.size() != 0 || busy) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checkOutput({name, " completes"}, 32'(sbQ.size() == 0 && !busy), 32'd1);
  endtask

  // Monitor: counts busy cycles and scores each finished move.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busyPrev = 1'b0;
      busyCnt  = 0;
    end else begin
      if (busy) begin
        busyCnt++;
      end else if (busyPrev) begin
        checkOutput("move expected", 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput({e.name, " grid"}, 32'(grid), 32'(e.gridExp));
          checkOutput({e.name, " lose"}, 32'(lose), 32'(e.loseExp));
          checkOutput({e.name, " busy cycles"}, 32'(busyCnt), 32'd5);
        end
        busyCnt = 0;
      end
      busyPrev = busy;
    end
  end

  initial begin
    logic [26:0] g;
    $display("[TB] starting move_controller bench");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset grid", 32'(grid), 32'h0000001);
    checkOutput("reset lose", 32'(lose), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset lfsr", 32'(dut.lfsr_q), 32'h000000A5);

    // Left move on the reset board changes nothing, so nothing spawns.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 27'h1, 27'h1, 1'b0, "noop left");
    checkOutput("noop busy", 32'(busy), 32'd1);
    waitIdle("noop left");

    // [1,1,2] left merges once into [2,2,0].
    g = mk(1, 1, 2, 0, 0, 0, 0, 0, 0);
    loadGrid(g, "load 112");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, g, mk(2, 2, 0, 0, 0, 0, 0, 0, 0), 1'b0, "merge left");
    @(negedge clk);
    checkOutput("row0 after LINE0", 32'(grid[8:0]), 32'h012);
    waitIdle("merge left");

    // Checkerboard cannot move: no spawn, loss flagged.
    g = mk(1, 2, 1, 2, 1, 2, 1, 2, 1);
    loadGrid(g, "load checker");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, g, g, 1'b1, "checker right");
    waitIdle("checker right");
    l = 1'b1;
    @(negedge clk);
    l = 1'b0;
    checkOutput("pulse ignored busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("pulse ignored grid", 32'(grid), 32'(g));
    checkOutput("lose sticky", 32'(lose), 32'd1);

    // Right beats up; a down pulse mid-move is dropped.
    g = mk(1, 0, 0, 0, 0, 2, 0, 0, 0);
    loadGrid(g, "load r+u");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, g, mk(0, 0, 1, 0, 0, 2, 0, 0, 0), 1'b0, "right over up");
    @(negedge clk);
    d = 1'b1;
    @(negedge clk);
    d = 1'b0;
    waitIdle("right over up");
    repeat (6) @(negedge clk);
    checkOutput("dropped down busy", 32'(busy), 32'd0);

    // Down on column0 [1,1,1]: the edge pair merges first.
    g = mk(1, 0, 0, 1, 0, 0, 1, 0, 0);
    loadGrid(g, "load col111");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, g, mk(0, 0, 0, 1, 0, 0, 2, 0, 0), 1'b0, "down col0");
    waitIdle("down col0");

    // Up on column1 [0,2,2]: compress then merge to 3.
    g = mk(0, 0, 0, 0, 2, 0, 0, 2, 0);
    loadGrid(g, "load col022");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, g, mk(0, 3, 0, 0, 0, 0, 0, 0, 0), 1'b0, "up col1");
    waitIdle("up col1");

    // Left on row2 [3,1,1]: the far pair merges.
    g = mk(0, 0, 0, 0, 0, 0, 3, 1, 1);
    loadGrid(g, "load row311");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, g, mk(0, 0, 0, 0, 0, 0, 3, 2, 0), 1'b0, "left far merge");
    waitIdle("left far merge");

    // Saturated tiles never merge.
    g = mk(7, 7, 0, 0, 0, 0, 0, 0, 0);
    loadGrid(g, "load 770");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, g, g, 1'b0, "saturated left");
    waitIdle("saturated left");

    // Reset during LINE1 of a right move discards it at once.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, g, mk(0, 7, 7, 0, 0, 0, 0, 0, 0), 1'b0, "aborted right");
    @(negedge clk);
    rst = 1'b1;
    sbQ.delete();
    #1;
    checkOutput("mid-move reset grid", 32'(grid), 32'h0000001);
    checkOutput("mid-move reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("post reset lfsr", 32'(dut.lfsr_q), 32'h000000A5);
    repeat (8) @(negedge clk);
    checkOutput("post reset idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
